// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/trap controller: cause codes,
// mcause layout and the trap sequencer state encoding.
package pipe_ctrl_pkg;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_EBREAK  = 4'd3;
  localparam logic [3:0] EXC_ECALL   = 4'd11;
  localparam logic [3:0] IRQ_EXT     = 4'd11;

  localparam int MCAUSE_INT_BIT = 31;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } trap_state_e;

  function automatic logic [31:0] irq_mcause(input logic [3:0] code);
    logic [31:0] v;
    v = {28'b0, code};
    v[MCAUSE_INT_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID consumer and an EX load.
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard  = ex_load && ex_valid && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_trap_ctrl.sv
// Central pipeline controller: stall/flush generation, next-PC redirect and
// precise trap sequencing with the machine trap CSRs.
module hazard_trap_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC        = 32'h0000_1000,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic        MIE_RESET    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic [31:0] ex_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        ex_exc,
  input  logic [3:0]  ex_exc_cause,
  input  logic        ex_mret,
  input  logic        irq,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        npc_sel,
  output logic [31:0] npc_target,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic        mie,
  output logic        trap_busy
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  trap_state_e      state;
  logic [CNT_W-1:0] drain_cnt;
  logic             mpie;

  logic load_use;
  logic run;
  logic take_exc;
  logic take_mret;
  logic take_irq;
  logic take_br;
  logic any_flush;

  load_use_detect u_load_use (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_load    (ex_load),
    .hazard     (load_use)
  );

  // Priority chain: each action masks every lower-priority one
  assign run       = (state == ST_RUN);
  assign take_exc  = run && ex_valid && ex_exc;
  assign take_mret = run && ex_mret && !take_exc;
  assign take_irq  = run && irq && mie && ex_valid && !take_exc && !take_mret;
  assign take_br   = run && ex_redirect && !take_exc && !take_mret && !take_irq;
  assign any_flush = take_exc || take_mret || take_irq || take_br;
  assign trap_busy = !run;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    npc_sel     = 1'b0;
    npc_target  = 32'h0;
    if (take_exc || take_irq) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      npc_sel     = 1'b1;
      npc_target  = MTVEC;
    end else if (take_mret) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      npc_sel    = 1'b1;
      npc_target = mepc;
    end else if (take_br) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      npc_sel    = 1'b1;
      npc_target = ex_target;
    end else if (load_use && !any_flush) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      mepc      <= 32'h0;
      mcause    <= 32'h0;
      mie       <= MIE_RESET;
      mpie      <= 1'b0;
    end else if (run) begin
      if (take_exc || take_irq) begin
        mepc      <= ex_pc;
        mcause    <= take_exc ? {28'b0, ex_exc_cause} : irq_mcause(IRQ_EXT);
        mpie      <= mie;
        mie       <= 1'b0;
        state     <= ST_DRAIN;
        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
      end else if (take_mret) begin
        mie       <= mpie;
        mpie      <= 1'b1;
        state     <= ST_DRAIN;
        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
      end
    end else begin
      if (drain_cnt == '0) begin
        state <= ST_RUN;
      end else begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_trap_ctrl.sv
// Directed scoreboard bench for hazard_trap_ctrl: stalls, redirects, traps,
// interrupt/mret round trip and reset during drain.
module tb_hazard_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_valid, ex_load;
  logic [31:0] ex_pc, ex_target;
  logic        ex_redirect, ex_exc, ex_mret, irq;
  logic [3:0]  ex_exc_cause;
  logic        pc_stall, ifid_stall, idex_stall;
  logic        ifid_flush, idex_flush, exmem_flush, npc_sel;
  logic [31:0] npc_target, mepc, mcause;
  logic        mie, trap_busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [39:0] ctrl;
  } exp_t;
  exp_t sb[$];

  hazard_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_load(ex_load), .ex_pc(ex_pc),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .ex_exc(ex_exc),
    .ex_exc_cause(ex_exc_cause), .ex_mret(ex_mret), .irq(irq),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .npc_sel(npc_sel), .npc_target(npc_target), .mepc(mepc), .mcause(mcause),
    .mie(mie), .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  // {stalls[3], flushes[3], npc_sel, npc_target, trap_busy}
  function automatic logic [39:0] cv(input logic [2:0] stl, input logic [2:0] fl,
                                     input logic sel, input logic [31:0] tgt,
                                     input logic busy);
    return {stl, fl, sel, tgt, busy};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [39:0] ctrl);
    exp_t e;
    e.tag  = tag;
    e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [39:0] obs;
    obs = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_flush,
           npc_sel, npc_target, trap_busy};
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 40'd1, 40'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.ctrl);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_load = 0; ex_pc = 0;
    ex_redirect = 0; ex_target = 0; ex_exc = 0; ex_exc_cause = 0;
    ex_mret = 0; irq = 0;
  endtask

  // Inputs were just driven: settle, compare controls, advance past the edge
  task automatic step();
    #2;
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_in(input logic [4:0] rd);
    ex_valid = 1; ex_load = 1; ex_rd = rd; id_rs1 = 5'd5; id_use_rs1 = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    push("reset_ctrl", cv(3'b000, 3'b000, 0, 0, 0));
    pop_check();
    chk("reset_csr", {mepc[7:0], mcause, mie}, {8'h0, 32'h0, 1'b1});
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    load_use_in(5'd5);
    push("load_use_rs1", cv(3'b111, 3'b000, 0, 0, 0)); step();
    ex_valid = 0;
    push("load_use_release", cv(3'b000, 3'b000, 0, 0, 0)); step();
    load_use_in(5'd0); id_rs1 = 5'd0;
    push("load_use_r0", cv(3'b000, 3'b000, 0, 0, 0)); step();
    idle(); ex_valid = 1; ex_load = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
    push("load_use_rs2", cv(3'b111, 3'b000, 0, 0, 0)); step();
    id_use_rs2 = 0; id_rs1 = 5'd7;
    push("load_use_unused_rs1", cv(3'b000, 3'b000, 0, 0, 0)); step();

    idle(); load_use_in(5'd5); ex_redirect = 1; ex_target = 32'h200;
    push("branch_over_stall", cv(3'b000, 3'b110, 1, 32'h200, 0)); step();

    idle(); ex_valid = 0; ex_exc = 1; ex_exc_cause = 4'd2; ex_pc = 32'h55;
    push("exc_no_valid", cv(3'b000, 3'b000, 0, 0, 0)); step();
    chk("exc_no_valid_csr", {mepc[7:0], mcause, mie}, {8'h0, 32'h0, 1'b1});

    idle(); ex_valid = 1; ex_exc = 1; ex_exc_cause = 4'd11; ex_pc = 32'h84;
    push("ecall", cv(3'b000, 3'b111, 1, 32'h1000, 0)); step();
    chk("ecall_csr", {mepc[7:0], mcause, mie}, {8'h84, 32'hB, 1'b0});
    ex_exc_cause = 4'd2; ex_pc = 32'h99; ex_redirect = 1; ex_target = 32'h300;
    push("drain1_ignore", cv(3'b000, 3'b000, 0, 0, 1)); step();
    chk("drain1_csr", {mepc[7:0], mcause, mie}, {8'h84, 32'hB, 1'b0});
    idle(); load_use_in(5'd5);
    push("drain2_load_use", cv(3'b111, 3'b000, 0, 0, 1)); step();

    idle(); ex_valid = 1; irq = 1; ex_pc = 32'h60;
    push("irq_masked", cv(3'b000, 3'b000, 0, 0, 0)); step();
    ex_mret = 1;
    push("mret_to_84", cv(3'b000, 3'b110, 1, 32'h84, 0)); step();
    chk("mret_csr", {mepc[7:0], mcause, mie}, {8'h84, 32'hB, 1'b1});
    ex_mret = 0;
    push("irq_drain1", cv(3'b000, 3'b000, 0, 0, 1)); step();
    push("irq_drain2", cv(3'b000, 3'b000, 0, 0, 1)); step();
    ex_pc = 32'h40;
    push("irq_taken", cv(3'b000, 3'b111, 1, 32'h1000, 0)); step();
    chk("irq_csr", {mepc[7:0], mcause, mie}, {8'h40, 32'h8000_000B, 1'b0});
    idle();
    push("irq_trap_drain1", cv(3'b000, 3'b000, 0, 0, 1)); step();
    push("irq_trap_drain2", cv(3'b000, 3'b000, 0, 0, 1)); step();
    ex_valid = 1; ex_mret = 1;
    push("mret_to_40", cv(3'b000, 3'b110, 1, 32'h40, 0)); step();
    chk("mret2_csr", {mepc[7:0], mcause, mie}, {8'h40, 32'h8000_000B, 1'b1});
    idle();
    push("mret2_drain1", cv(3'b000, 3'b000, 0, 0, 1)); step();
    push("mret2_drain2", cv(3'b000, 3'b000, 0, 0, 1)); step();

    ex_valid = 1; ex_exc = 1; ex_mret = 1; ex_exc_cause = 4'd3; ex_pc = 32'h10;
    push("exc_beats_mret", cv(3'b000, 3'b111, 1, 32'h1000, 0)); step();
    chk("ebreak_csr", {mepc[7:0], mcause, mie}, {8'h10, 32'h3, 1'b0});
    idle();
    push("ebreak_drain1", cv(3'b000, 3'b000, 0, 0, 1)); step();
    rst = 1;
    push("reset_mid_drain", cv(3'b000, 3'b000, 0, 0, 0));
    #2;
    pop_check();
    chk("reset_mid_drain_csr", {mepc[7:0], mcause, mie}, {8'h0, 32'h0, 1'b1});
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    load_use_in(5'd5);
    push("after_reset_load_use", cv(3'b111, 3'b000, 0, 0, 0)); step();

    chk("scoreboard_drained", 40'(sb.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
